// File: rtl/top_level_pkg.sv
// ----------------------------------------------------------------------------
// top_level_pkg
//   Shared constants and types for the registered 4-bit carry-lookahead adder.
//   ADD_W      : operand width (fixed at 4, bit 1 is the LSB)
//   RESET_SUM  : value the sum output takes after reset
//   operand_t  : [ADD_W:1] operand / sum vector
// ----------------------------------------------------------------------------
package top_level_pkg;

    localparam int unsigned ADD_W = 4;

    typedef logic [ADD_W:1] operand_t;

    localparam operand_t RESET_SUM = 4'b0000;

endpackage : top_level_pkg

// File: rtl/top_level_if.sv
// ----------------------------------------------------------------------------
// top_level_if
//   Operand/result bundle of the registered CLA adder.
//   x, y   : operands A and B, [4:1], bit 1 is the LSB
//   cin    : carry into bit 1
//   z      : sum, [4:1], bit 1 is the LSB
//   cout   : carry out of bit 4
//   Modports: master drives operands and observes results (stimulus side),
//             slave receives operands and drives results (adder side).
// ----------------------------------------------------------------------------
interface top_level_if;
    import top_level_pkg::*;

    operand_t x;
    operand_t y;
    logic     cin;
    operand_t z;
    logic     cout;

    modport master (
        output x,
        output y,
        output cin,
        input  z,
        input  cout
    );

    modport slave (
        input  x,
        input  y,
        input  cin,
        output z,
        output cout
    );

endinterface : top_level_if

// File: rtl/top_level_cla4_core.sv
// ----------------------------------------------------------------------------
// cla4_core
//   Purely combinational 4-bit carry-lookahead adder core. Every carry is a
//   flat sum-of-products of generate/propagate terms; no carry is fed through
//   another carry's logic.
//   a, b : operands [4:1], bit 1 is the LSB
//   ci   : carry into bit 1
//   s    : sum [4:1]
//   co   : carry out of bit 4
//   P    : group propagate p4p3p2p1 (for cascading)
//   G    : group generate (carry out with ci forced to 0, for cascading)
// ----------------------------------------------------------------------------
module cla4_core
    import top_level_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    input  logic     ci,
    output operand_t s,
    output logic     co,
    output logic     P,
    output logic     G
);

    operand_t g;
    operand_t p;
    logic     c1, c2, c3, c4, c5;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c1 = ci;
        c2 = g[1] | (p[1] & c1);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & c1);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & c1);
        c5 = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
                  | (p[4] & p[3] & p[2] & g[1])
                  | (p[4] & p[3] & p[2] & p[1] & c1);

        s[1] = p[1] ^ c1;
        s[2] = p[2] ^ c2;
        s[3] = p[3] ^ c3;
        s[4] = p[4] ^ c4;
        co   = c5;

        P = p[4] & p[3] & p[2] & p[1];
        G = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
                 | (p[4] & p[3] & p[2] & g[1]);
    end

endmodule : cla4_core

// File: rtl/top_level.sv
// ----------------------------------------------------------------------------
// top_level
//   Registered 4-bit carry-lookahead adder: {cout, z} = x + y + cin.
//   clk  : rising-edge clock for all registers
//   res  : synchronous active-high reset, clears every register
//   bus  : top_level_if.slave carrying x, y, cin in and z, cout out
//
//   Build option TOP_LEVEL_OUT_REG_EN:
//     defined   - z/cout come from output registers (2-edge latency)
//     undefined - z/cout come straight from the core fed by the input
//                 registers (1-edge latency); still 0 right after reset
//                 since the input registers clear.
// ----------------------------------------------------------------------------
module top_level
    import top_level_pkg::*;
(
    input  logic            clk,
    input  logic            res,
    top_level_if.slave      bus
);

    operand_t xr_q, xr_d;
    operand_t yr_q, yr_d;
    logic     cr_q, cr_d;

    operand_t core_s;
    logic     core_co;
    logic     grp_p;
    logic     grp_g;

    always_comb begin
        xr_d = bus.x;
        yr_d = bus.y;
        cr_d = bus.cin;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            xr_q <= '0;
            yr_q <= '0;
            cr_q <= 1'b0;
        end else begin
            xr_q <= xr_d;
            yr_q <= yr_d;
            cr_q <= cr_d;
        end
    end

    cla4_core u_cla4_core (
        .a  (xr_q),
        .b  (yr_q),
        .ci (cr_q),
        .s  (core_s),
        .co (core_co),
        .P  (grp_p),
        .G  (grp_g)
    );

    // Group terms must reproduce the ripple-free carry out when cascaded.
    always_comb begin
        assert (core_co == (grp_g | (grp_p & cr_q)));
    end

`ifdef TOP_LEVEL_OUT_REG_EN
    operand_t z_q, z_d;
    logic     cout_q, cout_d;

    always_comb begin
        z_d    = core_s;
        cout_d = core_co;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            z_q    <= RESET_SUM;
            cout_q <= 1'b0;
        end else begin
            z_q    <= z_d;
            cout_q <= cout_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.cout = cout_q;
`else
    assign bus.z    = core_s;
    assign bus.cout = core_co;
`endif

endmodule : top_level

// File: tb/tb_top_level.sv
// ----------------------------------------------------------------------------
// tb_top_level
//   Self-checking bench for top_level. A behavioural model turns each edge's
//   inputs into x+y+cin (or 0 under reset), delays it by the configured
//   latency, and a negedge process compares every cycle once a reset has
//   been seen. Directed steps add hand-computed literal expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_top_level;
    import top_level_pkg::*;

`ifdef TOP_LEVEL_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;

    top_level_if bus ();

    top_level dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: value each edge produces, held in a latency-length delay line.
    logic [4:0] pipe [$];
    logic [4:0] exp_val;
    bit         known = 0;

    always @(posedge clk) begin
        logic [4:0] v;
        v = res ? 5'd0 : (5'(bus.x) + 5'(bus.y) + 5'(bus.cin));
        if (res) begin
            pipe.delete();
            for (int unsigned i = 0; i < LAT; i++) pipe.push_back(5'd0);
            known = 1;
        end else if (known) begin
            pipe.push_back(v);
            void'(pipe.pop_front());
        end
        if (known) exp_val = (LAT == 1) ? pipe[$] : pipe[0];
    end

    // For LAT==2 the delay line holds [out_now, next]; push then pop keeps
    // index 0 as the value visible after this edge.
    always @(negedge clk) begin
        if (known) begin
            checks++;
            if ({bus.cout, bus.z} !== exp_val) begin
                errors++;
                $display("FAIL model_cmp t=%0t got cout=%b z=%b exp cout=%b z=%b",
                         $time, bus.cout, bus.z, exp_val[4], exp_val[3:0]);
            end
        end
    end

    task automatic lit(input string name, input logic [3:0] ez, input logic ec);
        checks++;
        if (bus.z !== ez || bus.cout !== ec) begin
            errors++;
            $display("FAIL %s got cout=%b z=%b exp cout=%b z=%b",
                     name, bus.cout, bus.z, ec, ez);
        end
    endtask

    task automatic drive(input logic [3:0] xv, input logic [3:0] yv, input logic cv);
        bus.x   = xv;
        bus.y   = yv;
        bus.cin = cv;
    endtask

    // Drive at a negedge, wait out the latency, check at the following negedge.
    task automatic op(input string name, input logic [3:0] xv, input logic [3:0] yv,
                      input logic cv, input logic [3:0] ez, input logic ec);
        drive(xv, yv, cv);
        repeat (LAT) @(negedge clk);
        lit(name, ez, ec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        lit("reset", 4'b0000, 1'b0);

        op("add_1_2",    4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0);
        op("add_3_2",    4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lit("hold", 4'b0101, 1'b0);
        end
        op("carry_f_1",  4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
        op("carry_f_f1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        // Back-to-back operand sets on consecutive edges.
        drive(4'b0101, 4'b0101, 1'b1);
        @(negedge clk);
        drive(4'b1000, 4'b1000, 1'b0);
        if (LAT == 2) @(negedge clk);
        lit("b2b_first", 4'b1011, 1'b0);
        @(negedge clk);
        lit("b2b_second", 4'b0000, 1'b1);

        // Exhaustive sweep, checked by the per-cycle model compare.
        for (int i = 0; i < 512; i++) begin
            drive(4'(i), 4'(i >> 4), 1'(i >> 8));
            @(negedge clk);
        end

        // Reset between two operand sets discards the pending result.
        drive(4'b0111, 4'b0001, 1'b0);
        @(negedge clk);
        res = 1'b1;
        drive(4'b0010, 4'b0011, 1'b0);
        @(negedge clk);
        res = 1'b0;
        lit("mid_reset_zero", 4'b0000, 1'b0);
        repeat (LAT) @(negedge clk);
        lit("after_reset", 4'b0101, 1'b0);

        // Random operands with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom), 4'($urandom), 1'($urandom));
            res = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        res = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_top_level

// File: doc/top_level.md
# top_level

Registered 4-bit carry-lookahead adder (CLA) that computes z = x + y + cin with a carry-out. Every carry is formed in parallel from generate/propagate terms, with no ripple chain. Inputs and results pass through clocked pipeline registers so the block can sit between synchronous stages. It is the top of the adder design and wraps one combinational CLA core.

## Interface
Parameters:
- none. Width is fixed at 4 by the package constant ADD_W = 4.

Ports:
- clk  in  1  rising-edge clock for all registers
- res  in  1  reset: one clock, synchronous, active-high; clears all registers at a clk rising edge while high
- x  in  4 [4:1]  operand A; bit 1 is the LSB
- y  in  4 [4:1]  operand B; bit 1 is the LSB
- cin  in  1  carry into bit 1
- cout  out  1  carry out of bit 4
- z  out  4 [4:1]  sum; bit 1 is the LSB

## Operation
- Input stage: at each clk rising edge, x, y and cin are captured into xr, yr, cr.
- Per bit i = 1..4:
  - g_i = xr_i & yr_i
  - p_i = xr_i ^ yr_i
- Carries, all as flat sum-of-products expansions (no chaining of c_i through logic levels):
  - c1 = cr
  - c2 = g1 | p1c1
  - c3 = g2 | p2g1 | p2p1c1
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1c1
  - c5 = g4 | p4g3 | p4p3g2 | p4p3p2g1 | p4p3p2p1c1
- Results:
  - sum_i = p_i ^ c_i
  - cout = c5
- Arithmetic: {cout, z} = x + y + cin, exact over the whole 0..31 range. Overflow simply wraps z modulo 16 with cout = 1; there is no saturation.
- Reset:
  - When res is high at a rising edge, xr, yr, cr and the output registers all load 0.
  - Outputs after reset: z = 4'b0000, cout = 0.
  - Reset takes priority over input capture at the same edge.
- At power-up before the first reset, outputs are unspecified (X permitted).

## Timing
- With output register enabled (default): operands applied before rising edge N appear on z/cout after rising edge N+1. Latency is 2 edges.
- Throughput: one new operand set per cycle, with no handshake and no stall.
- Reset mid-operation: any in-flight result is discarded. The first valid result after res deasserts is for operands captured at the first edge with res low.
- Inputs changing between edges have no effect until the next rising edge.
- The combinational path runs xr → g/p → carry SOP → XOR. It must fit in one clk period.

## Configuration
- TOP_LEVEL_OUT_REG_EN:
  - Defined (default build): z and cout are driven from output registers. Latency is 2 edges. Reset value is 0.
  - Undefined: z and cout are driven combinationally from the CLA core fed by xr/yr/cr. Latency is 1 edge. Outputs still read 0 immediately after reset because the input registers are cleared.

## Structure
- Package top_level_pkg:
  - ADD_W = 4
  - RESET_SUM = 4'b0000
  - a typedef for the 4-bit operand vector
- Sub-module cla4_core:
  - Purely combinational, no clock.
  - Ports: a[4:1], b[4:1], ci, s[4:1], co.
  - Also exports group propagate P = p4p3p2p1 and group generate G = c5 with ci forced to 0, for future cascading.
- top_level holds only the input registers, the optional output registers and one cla4_core instance.

## Test plan
- Hold res=1 for one edge with x=0000, y=0000, cin=0 → z=0000, cout=0 after the edge.
- x=0001, y=0010, cin=0 → z=0011, cout=0 after the latency.
- x=0011, y=0010, cin=0 → z=0101, cout=0. Then hold the inputs for 10 cycles → output stays stable.
- Carry through every bit:
  - x=1111, y=0001, cin=0 → z=0000, cout=1
  - x=1111, y=1111, cin=1 → z=1111, cout=1
- Back-to-back operands on consecutive cycles: 0101+0101 with cin=1, then 1000+1000 with cin=0 → results 1011/0, then 0000/1, on consecutive cycles in order.
- Exhaustive check of all 512 (x, y, cin) combinations against x+y+cin.
- Separately: assert res between two operand sets → the pending result is replaced by 0 and the next result is correct.
- Repeat the exhaustive and reset checks with TOP_LEVEL_OUT_REG_EN undefined, checking 1-edge latency.
